// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between a CPU store path and a debug path.
// Optional per-requester byte counters (cnt0/cnt1) are enabled with `define UART_ARB_STATS_EN.
module uart_tx_arbiter #(
   parameter int unsigned BUSY_TIMEOUT = 16,
   parameter int unsigned CNT_W        = 5
`ifdef UART_ARB_STATS_EN
   ,
   parameter int unsigned STAT_W       = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [7:0]        req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [7:0]        req1_data,
   output logic              req1_ready,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic              grant_id,
   output logic              arb_idle,
   output logic              err_timeout
`ifdef UART_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] cnt0,
   output logic [STAT_W-1:0] cnt1
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_START   = 2'd1,
      S_WAIT_HI = 2'd2,
      S_WAIT_LO = 2'd3
   } state_t;

   state_t           r_state,      w_state_nxt;
   logic             r_tx_start,   w_tx_start_nxt;
   logic [7:0]       r_tx_data,    w_tx_data_nxt;
   logic             r_grant,      w_grant_nxt;
   logic             r_last,       w_last_nxt;
   logic             r_err,        w_err_nxt;
   logic [CNT_W-1:0] r_cnt,        w_cnt_nxt;

   logic w_can_accept;
   logic w_win1;
   logic w_accept;

   // Winner: a lone valid wins; with both valid, the one not granted last time.
   assign w_win1       = req1_valid & (~req0_valid | ~r_last);
   assign w_can_accept = (r_state == S_IDLE) & ~tx_busy;
   assign req0_ready   = w_can_accept & req0_valid & ~w_win1;
   assign req1_ready   = w_can_accept & w_win1;
   assign w_accept     = req0_ready | req1_ready;

   assign arb_idle     = (r_state == S_IDLE);
   assign tx_start     = r_tx_start;
   assign tx_data      = r_tx_data;
   assign grant_id     = r_grant;
   assign err_timeout  = r_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_tx_start <= 1'b0;
         r_tx_data  <= 8'h00;
         r_grant    <= 1'b0;
         r_last     <= 1'b1;
         r_err      <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_tx_start <= w_tx_start_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_grant    <= w_grant_nxt;
         r_last     <= w_last_nxt;
         r_err      <= w_err_nxt;
         r_cnt      <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_tx_start_nxt = 1'b0;
      w_tx_data_nxt  = r_tx_data;
      w_grant_nxt    = r_grant;
      w_last_nxt     = r_last;
      w_err_nxt      = r_err;
      w_cnt_nxt      = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt    = S_START;
               w_tx_start_nxt = 1'b1;
               w_tx_data_nxt  = w_win1 ? req1_data : req0_data;
               w_grant_nxt    = w_win1;
               w_last_nxt     = w_win1;
            end
         end
         S_START: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            // Watchdog: transmitter never acknowledged the start pulse; drop the byte.
            if (tx_busy) begin
               w_state_nxt = S_WAIT_LO;
            end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_WAIT_LO: begin
            if (!tx_busy) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

`ifdef UART_ARB_STATS_EN
   logic [STAT_W-1:0] r_cnt0, r_cnt1;
   logic              w_done;

   assign w_done = (r_state == S_WAIT_LO) & ~tx_busy;
   assign cnt0   = r_cnt0;
   assign cnt1   = r_cnt1;

   // Completed bytes only; timed-out bytes never reach WAIT_LO.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (w_done) begin
         if (r_grant) r_cnt1 <= r_cnt1 + STAT_W'(1);
         else         r_cnt0 <= r_cnt0 + STAT_W'(1);
      end
   end
`endif

endmodule
